// File: rtl/rv32_isa_pkg.sv
// -----------------------------------------------------------------------------
// rv32_isa_pkg
// Shared RV32I definitions used by the immediate encoder and the matching
// sign-extension decoder:
//   - base opcode constants
//   - instruction format enum
//   - decode_fmt(): maps an opcode to the format that carries its immediate
// -----------------------------------------------------------------------------
package rv32_isa_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_INV
  } fmt_e;

  function automatic fmt_e decode_fmt(input logic [6:0] op);
    fmt_e fmt;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      OP_OP:                    fmt = FMT_R;
      default:                  fmt = FMT_INV;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// -----------------------------------------------------------------------------
// imm_encoder_if
// Request and response channels of the instruction encoder.
//   Request  : IN_VALID/IN_READY handshake carrying OPCODE, RD, RS1, RS2,
//              FUNCT3, FUNCT7 and the signed IMMEDIATE.
//   Response : OUT_VALID/OUT_READY handshake carrying INSTRUCTION and RANGE_ERR.
// master = program generator / loader side, slave = encoder side.
// -----------------------------------------------------------------------------
interface imm_encoder_if;

  logic        IN_VALID;
  logic        IN_READY;
  logic [6:0]  OPCODE;
  logic [4:0]  RD;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic [2:0]  FUNCT3;
  logic [6:0]  FUNCT7;
  logic [31:0] IMMEDIATE;

  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] INSTRUCTION;
  logic        RANGE_ERR;

  modport master (
    output IN_VALID, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMMEDIATE, OUT_READY,
    input  IN_READY, OUT_VALID, INSTRUCTION, RANGE_ERR
  );

  modport slave (
    input  IN_VALID, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMMEDIATE, OUT_READY,
    output IN_READY, OUT_VALID, INSTRUCTION, RANGE_ERR
  );

endinterface

// File: rtl/imm_range_check.sv
// -----------------------------------------------------------------------------
// imm_range_check
// Combinational check that a signed immediate fits the field layout of its
// instruction format.
//   i_fmt : instruction format
//   i_imm : signed immediate / byte offset
//   o_err : 1 when the immediate cannot be encoded (always 1 for FMT_INV)
// -----------------------------------------------------------------------------
module imm_range_check
  import rv32_isa_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [31:0] i_imm,
  output logic        o_err
);

  // NOTE: o_err gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    o_err = 1'b0;
    case (i_fmt)
      FMT_I, FMT_S: o_err = (i_imm != {{20{i_imm[11]}}, i_imm[11:0]});
      // Branch and jump offsets are halfword aligned; bit 0 is not encoded.
      FMT_B:        o_err = i_imm[0] || (i_imm != {{19{i_imm[12]}}, i_imm[12:0]});
      FMT_J:        o_err = i_imm[0] || (i_imm != {{11{i_imm[20]}}, i_imm[20:0]});
      FMT_U:        o_err = |i_imm[11:0];
      FMT_R:        o_err = 1'b0;
      default:      o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Two-stage RV32I instruction encoder (inverse of the immediate decoder).
//   S1 registers the request, its format and the immediate range error.
//   S2 registers the packed INSTRUCTION and RANGE_ERR.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : imm_encoder_if.slave (request and response handshakes)
//   ENC_COUNT  : accepted outputs, wraps
//   ERR_COUNT  : accepted outputs with RANGE_ERR=1, saturates at all-ones
// -----------------------------------------------------------------------------
module imm_encoder
  import rv32_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] ENC_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT
);

  logic             r_rdy_en;
  logic             r_s1_valid;
  fmt_e             r_s1_fmt;
  logic             r_s1_err;
  logic [6:0]       r_s1_op;
  logic [4:0]       r_s1_rd;
  logic [4:0]       r_s1_rs1;
  logic [4:0]       r_s1_rs2;
  logic [2:0]       r_s1_f3;
  logic [6:0]       r_s1_f7;
  logic [31:0]      r_s1_imm;
  logic             r_s2_valid;
  logic [31:0]      r_s2_instr;
  logic             r_s2_err;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  fmt_e        w_fmt;
  logic        w_err;
  logic        w_s2_adv;
  logic        w_in_ready;
  logic        w_in_fire;
  logic        w_out_fire;
  logic [31:0] w_instr;

  assign w_fmt = decode_fmt(bus.OPCODE);

  imm_range_check u_range (
    .i_fmt (w_fmt),
    .i_imm (bus.IMMEDIATE),
    .o_err (w_err)
  );

  // S2 (and S1 behind it) moves whenever the output slot is free or drained.
  // r_rdy_en keeps IN_READY low while in reset and for the cycle it is released.
  assign w_s2_adv   = !r_s2_valid || bus.OUT_READY;
  assign w_in_ready = r_rdy_en && (!r_s1_valid || w_s2_adv);
  assign w_in_fire  = bus.IN_VALID && w_in_ready;
  assign w_out_fire = r_s2_valid && bus.OUT_READY;

  // Out-of-range immediates are still packed from their truncated bits.
  always_comb begin
    w_instr = 32'h0000_0000;
    case (r_s1_fmt)
      FMT_I: w_instr = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      FMT_S: w_instr = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                        r_s1_imm[4:0], r_s1_op};
      FMT_B: w_instr = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1,
                        r_s1_f3, r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
      FMT_U: w_instr = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
      FMT_J: w_instr = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                        r_s1_imm[19:12], r_s1_rd, r_s1_op};
      FMT_R: w_instr = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      default: w_instr = 32'h0000_0000;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_fmt   <= FMT_I;
      r_s1_err   <= 1'b0;
      r_s1_op    <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_f3    <= '0;
      r_s1_f7    <= '0;
      r_s1_imm   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;

      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_fmt   <= w_fmt;
        r_s1_err   <= w_err;
        r_s1_op    <= bus.OPCODE;
        r_s1_rd    <= bus.RD;
        r_s1_rs1   <= bus.RS1;
        r_s1_rs2   <= bus.RS2;
        r_s1_f3    <= bus.FUNCT3;
        r_s1_f7    <= bus.FUNCT7;
        r_s1_imm   <= bus.IMMEDIATE;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= w_instr;
          r_s2_err   <= r_s1_err;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_out_fire) begin
      r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      if (r_s2_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.IN_READY    = w_in_ready;
  assign bus.OUT_VALID   = r_s2_valid;
  assign bus.INSTRUCTION = r_s2_instr;
  assign bus.RANGE_ERR   = r_s2_err;
  assign ENC_COUNT       = r_enc_cnt;
  assign ERR_COUNT       = r_err_cnt;

endmodule
